imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the core's immediate generator: takes an instruction template plus a 32-bit immediate and a format code, and packs the immediate bits into RV32I instruction positions.
- Range-checks the immediate for the chosen format.
- Expands the LI pseudo-op into a LUI/ADDI pair.
- Sits between the boot/test stimulus loader and instruction memory, with valid/ready on both sides and a registered output stage.

Parameters:
- DATA_WIDTH, 32, immediate and instruction width; only 32 supported.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_fmt  input  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=SHAMT, 6=LI, 7=reserved.
- in_base  input  32  template: opcode/funct/rd/rs fields; immediate bit positions ignored.
- in_imm  input  DATA_WIDTH  full-value immediate (byte offset for B/J, full value for U).
- out_valid  output  1  out_inst valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_inst  output  32  packed instruction.
- out_err  output  1  immediate out of range for fmt, or reserved fmt; qualified by out_valid.
- out_last  output  1  final word of this request.

Behaviour:
- Reset: state IDLE; out_valid=0, out_inst=0, out_err=0, out_last=0. in_ready is low while rst is high. Reset mid-expansion discards the pending LUI/ADDI.
- States: IDLE, ONE (single word held), HI (LUI held, ADDI pending), LO (ADDI held).
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - This gives back-to-back single-word throughput of one per cycle.
  - Nothing is accepted while a HI word is pending.
- Latency: request accepted in cycle N → out_valid in N+1. Output registers hold stable while out_valid && !out_ready.
- Packing (non-imm bits of out_inst come from in_base):
  - I: [31:20]=imm[11:0]. err if imm not in [-2048,2047].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same range as I.
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. err if imm[0]=1 or imm not in [-4096,4094].
  - U: [31:12]=imm[31:12]. err if imm[11:0]!=0.
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. err if imm[0]=1 or imm not in [-1048576,1048574].
  - SHAMT: [24:20]=imm[4:0], [31:25] kept from base so SRAI's bit 30 survives. err if imm>31 (unsigned).
  - On err the word is still packed from the truncated bits and emitted once, out_last=1.
- LI (rd = in_base[11:7]):
  - Compute lo = imm[11:0] sign-extended and hi = (imm + 32'h800) >> 12, mod 2^20.
  - If imm in [-2048,2047]: one word, ADDI rd,x0,imm (0x00000013 | rd<<7 | imm<<20). State ONE, out_last=1.
  - Else if imm[11:0]==0: one word, LUI rd,hi (opcode 0x37). State ONE.
  - Else: HI emits LUI rd,hi with out_last=0. On handshake move to LO and emit ADDI rd,rd,lo with out_last=1.
  - in_base fields other than rd are ignored for LI. out_err=0 always.
- fmt 7: emit in_base unchanged with out_err=1, out_last=1.
- Boundary cases:
  - imm=0x7FFFF800 under LI: hi=0x80000 wraps, yielding 0x80000 LUI + ADDI -2048 (correct mod 2^32).
  - imm=-2048 / 2047 are single-word.
  - out_ready held low in HI stalls indefinitely with no state change.

Decomposition:
- Shared package: fmt code constants, opcode constants OP_LUI=7'b0110111 and OP_IMM=7'b0010011, state encoding.
- One sub-module: imm_pack, purely combinational (fmt, base, imm → inst, err). The top module holds the FSM, the LI split and the output register.

Test Plan:
- Reset release, then fmt=I, base=0x00000093, imm=-1 → next cycle out_inst=0xFFF00093, err=0, last=1.
- fmt=B, base=0x00000063, imm=-4 → out_inst=0xFE000EE3. Then imm=3 → err=1. Then imm=4096 → err=1.
- fmt=LI, rd=x5, imm=0x12345FFF → LUI 0x123462B7 (last=0), then ADDI 0xFFF28293 (last=1). in_ready is low between the two words.
- out_ready low for 5 cycles during HI → out_inst/out_valid/out_last stable; no second request accepted.
- Back-to-back fmt=U imm=0xABCDE000 ×4 with out_ready=1 → one word per cycle, each 0xABCDE000|base.
- Assert rst while in state HI → all outputs 0 immediately. After release, a fresh fmt=SHAMT imm=40 request → err=1.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder.
// Holds the format codes, the two opcodes used by the LI split, the FSM
// state encoding and a signed range-check helper.
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_S     = 3'd1,
    FMT_B     = 3'd2,
    FMT_U     = 3'd3,
    FMT_J     = 3'd4,
    FMT_SHAMT = 3'd5,
    FMT_LI    = 3'd6,
    FMT_RSVD  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_e;

  // True when v fits in an n-bit two's complement field: every bit from
  // n-1 upward must be a copy of the sign bit.
  function automatic logic fits_signed(input logic signed [31:0] v,
                                       input int unsigned n);
    logic signed [31:0] t;
    t = v >>> (n - 1);
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: combinational packer that scatters an immediate into the
// RV32I bit positions of the selected format and flags out-of-range values.
// Ports:
//   fmt_i  - format code (fmt_e)
//   base_i - instruction template; immediate positions are overwritten
//   imm_i  - full-value immediate
//   inst_o - packed instruction (LI and reserved formats pass base through)
//   err_o  - immediate out of range for fmt, or reserved fmt
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [31:0] base_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        err_o
);

  logic signed [31:0] imm_s;
  assign imm_s = $signed(imm_i);

  always_comb begin
    inst_o = base_i;
    err_o  = 1'b0;
    case (fmt_e'(fmt_i))
      FMT_I: begin
        inst_o = {imm_i[11:0], base_i[19:0]};
        err_o  = !fits_signed(imm_s, 12);
      end
      FMT_S: begin
        inst_o = {imm_i[11:5], base_i[24:12], imm_i[4:0], base_i[6:0]};
        err_o  = !fits_signed(imm_s, 12);
      end
      FMT_B: begin
        inst_o = {imm_i[12], imm_i[10:5], base_i[24:12], imm_i[4:1],
                  imm_i[11], base_i[6:0]};
        // 13-bit signed range plus even alignment excludes +4095.
        err_o  = imm_i[0] || !fits_signed(imm_s, 13);
      end
      FMT_U: begin
        inst_o = {imm_i[31:12], base_i[11:0]};
        err_o  = |imm_i[11:0];
      end
      FMT_J: begin
        inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                  base_i[11:0]};
        err_o  = imm_i[0] || !fits_signed(imm_s, 21);
      end
      FMT_SHAMT: begin
        // Upper funct7 bits come from the template so SRAI keeps bit 30.
        inst_o = {base_i[31:25], imm_i[4:0], base_i[19:0]};
        err_o  = |imm_i[31:5];
      end
      FMT_LI: begin
        inst_o = base_i;
        err_o  = 1'b0;
      end
      default: begin
        inst_o = base_i;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: packs immediates into instruction templates between the
// stimulus loader and instruction memory. LI expands to one or two words
// (ADDI, LUI, or LUI followed by ADDI). Output stage is registered.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid/in_ready     - request handshake
//   in_fmt/in_base/in_imm - format code, template, immediate
//   out_valid/out_ready   - output handshake
//   out_inst/out_err      - packed word and range/format error
//   out_last              - final word of the current request
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [31:0]           in_base,
  input  logic [DATA_WIDTH-1:0] in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic                  out_err,
  output logic                  out_last
);

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_err_q, out_err_d;
  logic        out_last_q, out_last_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] pack_inst;
  logic        pack_err;

  imm_pack u_pack (
    .fmt_i  (in_fmt),
    .base_i (in_base),
    .imm_i  (in_imm),
    .inst_o (pack_inst),
    .err_o  (pack_err)
  );

  logic out_fire, accept;
  assign out_fire = out_valid_q && out_ready;
  assign in_ready = !rst && ((state_q == ST_IDLE) || (out_fire && out_last_q));
  assign accept   = in_valid && in_ready;

  // LI split: hi rounds up when the low 12 bits will sign-extend negative.
  logic [4:0]  li_rd;
  logic [19:0] li_hi;
  logic        li_small, li_round;
  assign li_rd    = in_base[11:7];
  assign li_hi    = in_imm[31:12] + {19'd0, in_imm[11]};
  assign li_small = fits_signed($signed(in_imm), 12);
  assign li_round = (in_imm[11:0] == 12'd0);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    pend_d      = pend_q;

    if (out_fire) begin
      if (state_q == ST_HI) begin
        state_d    = ST_LO;
        out_inst_d = pend_q;
        out_last_d = 1'b1;
      end else begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
        out_last_d  = 1'b0;
      end
    end

    if (accept) begin
      out_valid_d = 1'b1;
      state_d     = ST_ONE;
      out_last_d  = 1'b1;
      if (fmt_e'(in_fmt) == FMT_LI) begin
        out_err_d = 1'b0;
        if (li_small) begin
          out_inst_d = {in_imm[11:0], 5'd0, 3'b000, li_rd, OP_IMM};
        end else begin
          out_inst_d = {li_hi, li_rd, OP_LUI};
          if (!li_round) begin
            state_d    = ST_HI;
            out_last_d = 1'b0;
            pend_d     = {in_imm[11:0], li_rd, 3'b000, li_rd, OP_IMM};
          end
        end
      end else begin
        out_inst_d = pack_inst;
        out_err_d  = pack_err;
      end
    end
  end

  // Output stage / FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
    end
  end

  // Pending ADDI word is only read in HI, which reset always leaves.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        out_last;

  int vectors     = 0;
  int miscompares = 0;

  imm_encoder #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_base   (in_base),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Which immediate bit lands in instruction bit pos for a format, or -1.
  function automatic int imm_src(input int f, input int pos);
    case (f)
      0: return (pos >= 20) ? pos - 20 : -1;
      1: if (pos >= 25) return pos - 20;
         else if (pos >= 7 && pos <= 11) return pos - 7;
         else return -1;
      2: if (pos == 31) return 12;
         else if (pos >= 25) return pos - 20;
         else if (pos >= 8 && pos <= 11) return pos - 7;
         else if (pos == 7) return 11;
         else return -1;
      3: return (pos >= 12) ? pos : -1;
      4: if (pos == 31) return 20;
         else if (pos >= 21) return pos - 20;
         else if (pos == 20) return 11;
         else if (pos >= 12) return pos;
         else return -1;
      5: return (pos >= 20 && pos <= 24) ? pos - 20 : -1;
      default: return -1;
    endcase
  endfunction

  // Reference model: expected word count, words, and error flag.
  task automatic model(input int f, input logic [31:0] base, input logic [31:0] imm,
                       output int n, output logic [31:0] w0, output logic [31:0] w1,
                       output logic err);
    longint s;
    logic [31:0] rd, hi;
    int src;
    s   = longint'($signed(imm));
    n   = 1;
    w0  = base;
    w1  = 32'd0;
    err = 1'b0;
    if (f == 6) begin
      rd = {27'd0, base[11:7]};
      if (s >= -2048 && s <= 2047) begin
        w0 = 32'h13 | (rd << 7) | (imm << 20);
      end else begin
        hi = ((imm + 32'h800) >> 12) & 32'hFFFFF;
        w0 = (hi << 12) | (rd << 7) | 32'h37;
        if ((imm & 32'hFFF) != 0) begin
          n  = 2;
          w1 = (imm << 20) | (rd << 15) | (rd << 7) | 32'h13;
        end
      end
    end else if (f == 7) begin
      err = 1'b1;
    end else begin
      for (int p = 0; p < 32; p++) begin
        src = imm_src(f, p);
        if (src >= 0) w0[p] = imm[src];
      end
      case (f)
        0, 1: err = (s < -2048) || (s > 2047);
        2:    err = imm[0] || (s < -4096) || (s > 4094);
        3:    err = (imm & 32'hFFF) != 0;
        4:    err = imm[0] || (s < -1048576) || (s > 1048574);
        default: err = imm > 32'd31;
      endcase
    end
  endtask

  // Issue one request from IDLE, then drain every word, stalling each
  // word for `stall` cycles with out_ready low.
  task automatic do_req(input int f, input logic [31:0] base, input logic [31:0] imm,
                        input int stall);
    int n;
    logic [31:0] w0, w1, w;
    logic err;
    model(f, base, imm, n, w0, w1, err);
    @(negedge clk);
    in_valid  = 1'b1;
    in_fmt    = f[2:0];
    in_base   = base;
    in_imm    = imm;
    out_ready = 1'b0;
    #1 chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : w1;
      chk("valid", {31'd0, out_valid}, 32'd1);
      chk("inst", out_inst, w);
      chk("err", {31'd0, out_err}, {31'd0, err});
      chk("last", {31'd0, out_last}, (k == n - 1) ? 32'd1 : 32'd0);
      for (int st = 0; st < stall; st++) begin
        @(posedge clk);
        #1;
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_inst", out_inst, w);
        chk("stall_last", {31'd0, out_last}, (k == n - 1) ? 32'd1 : 32'd0);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    chk("drained", {31'd0, out_valid}, 32'd0);
  endtask

  logic [31:0] rimm, rbase;
  int          rfmt;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_fmt    = 3'd0;
    in_base   = 32'd0;
    in_imm    = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_err", {31'd0, out_err}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_req(0, 32'h00000093, 32'hFFFFFFFF, 0);
    do_req(2, 32'h00000063, 32'hFFFFFFFC, 0);
    do_req(2, 32'h00000063, 32'd3, 0);
    do_req(2, 32'h00000063, 32'd4096, 0);
    do_req(2, 32'h00000063, 32'd4094, 0);
    do_req(2, 32'h00000063, 32'hFFFFF000, 0);
    do_req(0, 32'h00000093, 32'd2047, 0);
    do_req(0, 32'h00000093, 32'hFFFFF800, 0);
    do_req(0, 32'h00000093, 32'd2048, 1);
    do_req(1, 32'h00002023, 32'hFFFFF7FF, 0);
    do_req(3, 32'h00000537, 32'hABCDE001, 0);
    do_req(4, 32'h0000006F, 32'h000FFFFE, 0);
    do_req(4, 32'h0000006F, 32'h00100000, 0);
    do_req(5, 32'h40005013, 32'd31, 0);
    do_req(7, 32'hDEADBEEF, 32'd0, 0);
    do_req(6, 32'h00000280, 32'h12345FFF, 5);
    do_req(6, 32'h00000280, 32'h7FFFF800, 0);
    do_req(6, 32'h00000300, 32'hFFFFF800, 0);
    do_req(6, 32'h00000300, 32'd2047, 0);
    do_req(6, 32'h00000300, 32'd2048, 0);
    do_req(6, 32'hFFFFFFFF, 32'h12345000, 0);

    // Back-to-back U words, one per cycle
    @(negedge clk);
    in_valid  = 1'b1;
    in_fmt    = 3'd3;
    in_base   = 32'h00000537;
    in_imm    = 32'hABCDE000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_inst", out_inst, 32'hABCDE537);
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      if (i == 3) in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Reset while the LUI of a two-word LI is held
    @(negedge clk);
    in_valid = 1'b1;
    in_fmt   = 3'd6;
    in_base  = 32'h00000280;
    in_imm   = 32'h12345FFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("hi_last", {31'd0, out_last}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_inst", out_inst, 32'd0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_req(5, 32'h40005013, 32'd40, 0);

    // Randomized requests against the model
    for (int r = 0; r < 200; r++) begin
      rfmt  = $urandom_range(0, 7);
      rbase = $urandom;
      case ($urandom_range(0, 3))
        0: rimm = $urandom_range(0, 8191) - 4096;
        1: rimm = $urandom_range(0, 4194303) - 2097152;
        2: rimm = $urandom;
        default: rimm = $urandom & 32'hFFFFF000;
      endcase
      if (rfmt == 5 && $urandom_range(0, 1) == 1) rimm = $urandom_range(0, 40);
      do_req(rfmt, rbase, rimm, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
